// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead receive FIFO, clocked by the core clock.
// Bit timing comes from an internal clock-cycle counter; the rx pin is synchronised before use.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  MID  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t            state, state_nx;
  logic              rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              cnt_clr, bit_clr, sample, push_req, frame_set;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  // Synchroniser and previous-sample flop for falling-edge detection; idle level is 1.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nx  = state;
    cnt_clr   = 1'b0;
    bit_clr   = 1'b0;
    sample    = 1'b0;
    push_req  = 1'b0;
    frame_set = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (rx_prev && !rx_s) state_nx = START;
      end
      START: begin
        if (bit_cnt == MID) begin
          cnt_clr = 1'b1;
          if (!rx_s) begin
            state_nx = DATA;
            bit_clr  = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_cnt == LAST) begin
          cnt_clr = 1'b1;
          sample  = 1'b1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (bit_cnt == LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            push_req = 1'b1;
            state_nx = IDLE;   // straight to IDLE so a zero-gap next start edge is caught
          end else begin
            frame_set = 1'b1;
            state_nx  = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_clr = 1'b1;
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_clr ? '0 : bit_cnt + 1'b1;
      if (bit_clr)     bit_idx <= '0;
      else if (sample) bit_idx <= bit_idx + 1'b1;
      if (sample)      shift   <= {rx_s, shift[7:1]};
    end
  end

  // A push into a full FIFO still lands when the same cycle pops the head.
  assign do_pop  = rd_en && !empty;
  assign do_push = push_req && (!full || rd_en);

  // NOTE: the storage array is not reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !rd_en) overrun <= 1'b1;
      else if (clr_err)               overrun <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive path for the single-cycle RISC-V core's UART peripheral: 8N1 deserialiser plus receive FIFO.
- Runs on the core clock; bit timing comes from an internal divider, not a separate UART clock.
- Sits between the external RX pin and the core's UART read port. A load decoded as UART read drives rd_en and takes rd_data into the register file.

Parameters:
- CLKS_PER_BIT, 10416, core clock cycles per serial bit (100 MHz / 9600 baud); must be >= 4.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, >= 2.
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- clk  input  1  core clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- rx  input  1  serial line; idle high; asynchronous to clk.
- rd_en  input  1  pop request from the core's UART read.
- clr_err  input  1  clears the sticky error flags.
- rd_data  output  8  FIFO head byte (show-ahead); 0 when empty.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- count  output  ADDR_W+1  number of bytes held.
- overrun  output  1  sticky: a received byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: the stop bit was sampled low.

Behaviour:
- Reset (reset=0 at a clk edge):
  - Pointers and count = 0; empty=1, full=0, rd_data=0, overrun=0, frame_err=0.
  - FSM = IDLE; synchroniser flops = 1.
  - Reset mid-frame abandons the frame; no partial byte is pushed.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s; edge detection uses the previous rx_s.
- Bit counter: 0..CLKS_PER_BIT-1 clock counter; "mid" = count of CLKS_PER_BIT/2 (integer divide).
- FSM:
  - IDLE: on a falling edge of rx_s, clear the counter and go to START.
  - START: at mid, if rx_s=0, reset the counter and go to DATA with bit index 0. If rx_s=1, treat as a glitch and return to IDLE; no flags change.
  - DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit), LSB first into the shift register. After bit 7, go to STOP.
  - STOP: sample at mid-bit.
    - rx_s=1: push the byte (see FIFO rules) and go to IDLE in the same cycle. This allows a back-to-back start edge with zero idle.
    - rx_s=0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE.
- FIFO (show-ahead):
  - rd_data = mem[rd_ptr] combinationally when not empty, else 0.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO push, at the STOP-sample cycle:
  - Not full: write at wr_ptr and increment it.
  - Full and rd_en=1 in the same cycle: pop and push both occur; count stays FIFO_DEPTH.
  - Full and rd_en=0: byte dropped; overrun set.
- FIFO pop (rd_en=1):
  - Not empty: rd_ptr increments.
  - Empty: ignored; no state change, no error. A simultaneous push still lands, so count becomes 1.
- Push and pop in the same cycle while not empty and not full: count unchanged.
- Latency: count, empty and rd_data update on the clk edge that performs the push, so they are visible the cycle after the stop-bit mid-sample. Total rx-to-visible latency ≈ 2 synchroniser cycles + 9.5 bit times.
- Sticky flags: cleared by clr_err=1. If a set event and clr_err occur in the same cycle, the flag ends at 1.
- count = wr-rd occupancy in ADDR_W+1 bits; full = (count==FIFO_DEPTH); empty = (count==0).

Test Plan:
- Setup: CLKS_PER_BIT=16, FIFO_DEPTH=4, ADDR_W=2.
- Single byte: drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → empty falls within 2 cycles after the stop mid-sample; rd_data=0xA5, count=1. Pulse rd_en → empty=1, rd_data=0.
- Glitch and framing: a 4-cycle low pulse on idle rx → no state change, flags 0. Then send 0x3C with stop bit held low for 3 bits → frame_err=1, count=0. After rx returns high, 0x55 is received normally. clr_err → frame_err=0.
- Overrun: send 5 back-to-back bytes 0x01..0x05 with no reads → full=1, count=4, overrun=1. Reads return 0x01..0x04, then empty=1.
- Simultaneous push/pop at full: FIFO full with 0x10..0x13; assert rd_en exactly on the 5th byte's (0x14) stop-sample cycle → overrun stays 0, count=4. Subsequent reads return 0x11,0x12,0x13,0x14.
- Reset mid-operation: reset=0 for 1 cycle during DATA bit 3 of 0xFF with 2 bytes queued → count=0, empty=1, flags 0. The next full frame 0x81 is received correctly.
- Wrap-around and empty-pop: 10 sequential write/read pairs (0x00..0x09) cross the pointer wrap with data intact. rd_en on empty is ignored, with count staying 0.
